// File: rtl/demux_tdm_pkg.sv
// Shared definitions for the 1:4 TDM demultiplexer: FSM encoding and slot sizing.
package demux_tdm_pkg;

  localparam int unsigned NSLOT = 4;
  localparam int unsigned SlotW = 2;

  typedef enum logic {
    StHunt   = 1'b0,
    StLocked = 1'b1
  } state_e;

  typedef logic [SlotW-1:0] slot_t;

endpackage

// File: rtl/slot_counter.sv
// Slot index counter: clear beats load-to-1, load beats enable; wraps naturally at 3 -> 0.
module slot_counter
  import demux_tdm_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic             clr,
  output logic [SlotW-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= SlotW'(1);
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/demux1x4_tdm.sv
// 1:4 TDM demultiplexer with frame hunting; publishes only complete frames, all outputs registered.
module demux1x4_tdm
  import demux_tdm_pkg::*;
#(
  parameter int unsigned DW    = 8,
  parameter int unsigned NSLOT = demux_tdm_pkg::NSLOT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] in,
  input  logic          in_valid,
  input  logic          frame,
  output logic [DW-1:0] out0,
  output logic [DW-1:0] out1,
  output logic [DW-1:0] out2,
  output logic [DW-1:0] out3,
  output logic          frame_valid,
  output logic          sel1,
  output logic          sel0,
  output logic          locked,
  output logic          sync_err
);

  localparam slot_t LastSlot = slot_t'(NSLOT - 1);

  state_e        state_q;
  slot_t         slot;
  logic [DW-1:0] shadow_q [NSLOT];

  logic is_locked;
  logic hunt_start, resync, lost, advance;

  assign is_locked  = (state_q == StLocked);
  assign hunt_start = in_valid && !is_locked && frame;
  // Frame marker arriving early: restart the frame from this beat.
  assign resync     = in_valid && is_locked && frame && (slot != '0);
  // Frame marker missing where slot 0 was expected: lose lock.
  assign lost       = in_valid && is_locked && !frame && (slot == '0);
  assign advance    = in_valid && is_locked && !resync && !lost;

  slot_counter u_slot_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (advance),
    .load  (hunt_start || resync),
    .clr   (lost),
    .cnt   (slot)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StHunt;
      out0        <= '0;
      out1        <= '0;
      out2        <= '0;
      out3        <= '0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
      for (int i = 0; i < NSLOT; i++) shadow_q[i] <= '0;
    end else begin
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
      if (hunt_start) begin
        shadow_q[0] <= in;
        state_q     <= StLocked;
      end
      if (resync) begin
        sync_err    <= 1'b1;
        shadow_q[0] <= in;
        for (int i = 1; i < NSLOT; i++) shadow_q[i] <= '0;
      end
      if (lost) begin
        sync_err <= 1'b1;
        state_q  <= StHunt;
      end
      if (advance) begin
        shadow_q[slot] <= in;
        if (slot == LastSlot) begin
          out0        <= shadow_q[0];
          out1        <= shadow_q[1];
          out2        <= shadow_q[2];
          out3        <= in;
          frame_valid <= 1'b1;
        end
      end
    end
  end

  assign locked     = is_locked;
  assign {sel1, sel0} = slot;

endmodule

// File: tb/tb_demux1x4_tdm.sv
// Self-checking bench for demux1x4_tdm: vector table plus hand sequences, frames via scoreboard.
module tb_demux1x4_tdm;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in = 8'h00;
  logic       in_valid = 1'b0;
  logic       frame = 1'b0;
  logic [7:0] out0, out1, out2, out3;
  logic       frame_valid, sel1, sel0, locked, sync_err;

  int total = 0;
  int bad   = 0;
  logic [31:0] sbq[$];

  demux1x4_tdm #(.DW(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in          (in),
    .in_valid    (in_valid),
    .frame       (frame),
    .out0        (out0),
    .out1        (out1),
    .out2        (out2),
    .out3        (out3),
    .frame_valid (frame_valid),
    .sel1        (sel1),
    .sel0        (sel0),
    .locked      (locked),
    .sync_err    (sync_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        v;
    logic        f;
    logic [7:0]  d;
    logic        e_locked;
    logic [1:0]  e_sel;
    logic        e_err;
    logic        e_fv;
    logic        push;
    logic [31:0] e_out;
  } vec_t;

  function automatic vec_t mk(logic v, logic f, logic [7:0] d, logic el, logic [1:0] es,
                              logic ee, logic efv, logic pu, logic [31:0] eo);
    vec_t r;
    r.v = v; r.f = f; r.d = d; r.e_locked = el; r.e_sel = es;
    r.e_err = ee; r.e_fv = efv; r.push = pu; r.e_out = eo;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] outs();
    return {out0, out1, out2, out3};
  endfunction

  task automatic step(input logic v, input logic f, input logic [7:0] d);
    in_valid = v;
    frame    = f;
    in       = d;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every frame_valid pulse must match the oldest pending frame.
  always @(negedge clk) begin
    chk("fv_err_overlap", {31'b0, frame_valid & sync_err}, 32'd0);
    if (frame_valid) begin
      chk("fv_has_pending_frame", {31'b0, sbq.size() > 0}, 32'd1);
      if (sbq.size() > 0) chk("frame_data", outs(), sbq.pop_front());
    end
  end

  vec_t tbl[$];
  logic [7:0]  gap_d[4];
  logic [31:0] prev;

  initial begin
    // In HUNT, non-frame beats are ignored.
    for (int i = 0; i < 5; i++) tbl.push_back(mk(1, 0, 8'h90 + 8'(i), 0, 2'd0, 0, 0, 0, 32'h0));
    // Back-to-back frame.
    tbl.push_back(mk(1, 1, 8'h11, 1, 2'd1, 0, 0, 0, 32'h0));
    tbl.push_back(mk(1, 0, 8'h22, 1, 2'd2, 0, 0, 0, 32'h0));
    tbl.push_back(mk(1, 0, 8'h33, 1, 2'd3, 0, 0, 0, 32'h0));
    tbl.push_back(mk(1, 0, 8'h44, 1, 2'd0, 0, 1, 1, 32'h11223344));
    tbl.push_back(mk(0, 1, 8'hFF, 1, 2'd0, 0, 0, 0, 32'h11223344));
    // Early frame marker on expected slot 2 restarts the frame.
    tbl.push_back(mk(1, 1, 8'h55, 1, 2'd1, 0, 0, 0, 32'h11223344));
    tbl.push_back(mk(1, 0, 8'h66, 1, 2'd2, 0, 0, 0, 32'h11223344));
    tbl.push_back(mk(1, 1, 8'hAA, 1, 2'd1, 1, 0, 0, 32'h11223344));
    tbl.push_back(mk(1, 0, 8'hBB, 1, 2'd2, 0, 0, 0, 32'h11223344));
    tbl.push_back(mk(1, 0, 8'hCC, 1, 2'd3, 0, 0, 0, 32'h11223344));
    tbl.push_back(mk(1, 0, 8'hDD, 1, 2'd0, 0, 1, 1, 32'hAABBCCDD));
    // Missing frame marker on slot 0 drops lock, outputs retained.
    tbl.push_back(mk(1, 0, 8'hEE, 0, 2'd0, 1, 0, 0, 32'hAABBCCDD));
    tbl.push_back(mk(1, 1, 8'h01, 1, 2'd1, 0, 0, 0, 32'hAABBCCDD));
    tbl.push_back(mk(1, 0, 8'h02, 1, 2'd2, 0, 0, 0, 32'hAABBCCDD));
    tbl.push_back(mk(1, 0, 8'h03, 1, 2'd3, 0, 0, 0, 32'hAABBCCDD));
    tbl.push_back(mk(1, 0, 8'h04, 1, 2'd0, 0, 1, 1, 32'h01020304));

    #1;
    chk("reset_outs", outs(), 32'h0);
    chk("reset_locked", {31'b0, locked}, 32'd0);
    chk("reset_sel", {30'b0, sel1, sel0}, 32'd0);
    chk("reset_pulses", {30'b0, frame_valid, sync_err}, 32'd0);
    #22 rst_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (tbl[i]) begin
      if (tbl[i].push) sbq.push_back(tbl[i].e_out);
      step(tbl[i].v, tbl[i].f, tbl[i].d);
      chk($sformatf("vec%0d_locked", i), {31'b0, locked}, {31'b0, tbl[i].e_locked});
      chk($sformatf("vec%0d_sel", i), {30'b0, sel1, sel0}, {30'b0, tbl[i].e_sel});
      chk($sformatf("vec%0d_sync_err", i), {31'b0, sync_err}, {31'b0, tbl[i].e_err});
      chk($sformatf("vec%0d_fv", i), {31'b0, frame_valid}, {31'b0, tbl[i].e_fv});
      chk($sformatf("vec%0d_outs", i), outs(), tbl[i].e_out);
    end

    // Same frame with 3-cycle gaps: outputs hold until the slot-3 beat.
    gap_d[0] = 8'h11; gap_d[1] = 8'h22; gap_d[2] = 8'h33; gap_d[3] = 8'h44;
    prev = 32'h01020304;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) sbq.push_back(32'h11223344);
      step(1'b1, i == 0, gap_d[i]);
      if (i < 3) begin
        chk("gap_beat_fv", {31'b0, frame_valid}, 32'd0);
        for (int g = 0; g < 3; g++) begin
          step(1'b0, 1'b0, 8'hEE);
          chk("gap_hold_outs", outs(), prev);
          chk("gap_hold_fv", {31'b0, frame_valid}, 32'd0);
          chk("gap_hold_sel", {30'b0, sel1, sel0}, 32'(i + 1));
        end
      end
    end
    chk("gap_frame_fv", {31'b0, frame_valid}, 32'd1);
    chk("gap_frame_outs", outs(), 32'h11223344);

    // Asynchronous reset mid-frame.
    step(1'b1, 1'b1, 8'h5A);
    step(1'b1, 1'b0, 8'h5B);
    step(1'b0, 1'b0, 8'h00);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_outs", outs(), 32'h0);
    chk("async_rst_locked", {31'b0, locked}, 32'd0);
    chk("async_rst_sel", {30'b0, sel1, sel0}, 32'd0);
    #12 rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h77);
    chk("post_rst_hunt", {31'b0, locked}, 32'd0);
    chk("post_rst_outs", outs(), 32'h0);
    step(1'b1, 1'b1, 8'hC1);
    step(1'b1, 1'b0, 8'hC2);
    step(1'b1, 1'b0, 8'hC3);
    chk("post_rst_no_fv", {31'b0, frame_valid}, 32'd0);
    sbq.push_back(32'hC1C2C3C4);
    step(1'b1, 1'b0, 8'hC4);
    chk("post_rst_frame", outs(), 32'hC1C2C3C4);
    step(1'b0, 1'b0, 8'h00);
    chk("post_frame_fv_one_cycle", {31'b0, frame_valid}, 32'd0);
    step(1'b0, 1'b0, 8'h00);
    chk("scoreboard_drained", sbq.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/demux1x4_tdm.md
DEMUX1X4_TDM -- requirements
Module: demux1x4_tdm

Interface
REQ-001 Parameter DW, default 8: bit width of each channel sample.
REQ-002 Parameter NSLOT, fixed 4: slots per frame; SHALL NOT be overridden.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in  input  DW  TDM data sample for the current slot.
REQ-006 in_valid  input  1  in/frame qualify this cycle as one slot beat.
REQ-007 frame  input  1  marks the beat carrying slot 0; meaningful only with in_valid.
REQ-008 out0..out3  output  DW each  last complete frame, channels 0..3.
REQ-009 frame_valid  output  1  one-cycle pulse: out0..out3 just updated.
REQ-010 sel1, sel0  output  1 each  slot index of the next expected beat (sel1 = MSB).
REQ-011 locked  output  1  high while in LOCKED state.
REQ-012 sync_err  output  1  one-cycle pulse on a framing violation.

Function
REQ-013 Two-state FSM: HUNT, LOCKED; reset state HUNT.
REQ-014 In HUNT, beats with frame=0 SHALL be discarded; slot counter held at 0.
REQ-015 In HUNT, a beat with frame=1 SHALL be captured as slot 0; counter goes to 1; FSM goes to LOCKED.
REQ-016 In LOCKED, each beat SHALL store in into shadow register [slot] and advance slot modulo 4 (3 -> 0 wrap).
REQ-017 Cycles with in_valid=0 SHALL change no state; gaps of any length between beats are allowed.
REQ-018 On the slot-3 beat, out0..out3 SHALL load shadow[0..2] plus the slot-3 sample, all in the same edge, and frame_valid SHALL be 1 for exactly the following cycle.
REQ-019 Latency from the slot-3 beat edge to the visible outputs: 1 clock; outputs SHALL otherwise hold their value.
REQ-020 No partial frame SHALL ever reach out0..out3.
REQ-021 In LOCKED, frame=1 on a beat with expected slot != 0: pulse sync_err, discard the shadow contents, capture the beat as slot 0, counter goes to 1, stay LOCKED.
REQ-022 In LOCKED, frame=0 on a beat with expected slot == 0: pulse sync_err, discard the beat, go to HUNT, counter goes to 0.
REQ-023 sync_err and frame_valid SHALL never be high in the same cycle, because the slot-3 beat cannot raise an error.
REQ-024 {sel1,sel0} SHALL equal the registered slot counter, and locked SHALL equal (state == LOCKED).

Reset
REQ-025 While rst_n=0, the block SHALL hold: state HUNT, slot 0, out0..out3 = 0, shadow = 0, frame_valid = 0, sync_err = 0, locked = 0.
REQ-026 Reset asserted mid-frame SHALL discard the partial frame, and no frame_valid SHALL follow reset release.
REQ-027 After reset deasserts, the first active edge SHALL behave as HUNT.

Structure
REQ-028 A shared package demux_tdm_pkg SHALL hold the FSM state encoding (HUNT=0, LOCKED=1), NSLOT=4 and slot-index width 2.
REQ-029 The slot counter SHALL be a separate sub-module, slot_counter: 2-bit, with enable, synchronous load-to-1, clear-to-0 and async active-low reset.
REQ-030 All outputs SHALL be registered, with no combinational path from inputs to outputs.

Verification
REQ-031 Reset, then beats {frame=1,in=8'h11},{0,8'h22},{0,8'h33},{0,8'h44}, back-to-back -> one cycle after the 4th beat: out0..3 = 11,22,33,44; frame_valid pulses once; locked=1.
REQ-032 Same frame with in_valid=0 gaps of 3 cycles between beats -> identical outputs; frame_valid only after the slot-3 beat; outputs unchanged during the gaps.
REQ-033 Locked, then frame=1 on expected slot 2 (in=8'hAA), then 3 more beats BB,CC,DD -> sync_err pulse on the violating beat; next outputs = AA,BB,CC,DD.
REQ-034 Locked, then frame=0 on expected slot 0 -> sync_err pulse; locked=0; sel=00; outputs retain the prior frame; the next frame=1 beat relocks.
REQ-035 rst_n pulsed low asynchronously (between edges) after slot 1 of a frame -> all outputs 0 immediately; no frame_valid after release until a full new frame completes.
REQ-036 HUNT with 5 beats at frame=0 -> no state change, locked=0, sel=00, no pulses.
